// File: rtl/reg_write_arbiter_pkg.sv
// Shared defaults and arbiter state type for the register write arbiter.
package reg_arb_pkg;
  localparam int NUM_REQ_DEF = 4;
  localparam int DATA_W_DEF  = 32;
  localparam int ADDR_W_DEF  = 2;
  localparam int LOCK_MAX    = 8;

  typedef enum logic [1:0] {IDLE, GRANT, LOCKED} arb_state_t;
endpackage

// File: rtl/reg_write_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request after ptr wins (one-hot).
module rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int PW      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PW-1:0]      ptr,
  output logic [NUM_REQ-1:0] win,
  output logic               valid
);
  logic [PW-1:0] idx;

  always_comb begin
    win   = '0;
    valid = 1'b0;
    idx   = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = PW'((int'(ptr) + k) % NUM_REQ);
      if (!valid && req[idx]) begin
        win[idx] = 1'b1;
        valid    = 1'b1;
      end
    end
  end
endmodule

// File: rtl/reg_write_arbiter.sv
// Round-robin register-bank write arbiter with registered grant, enable and data.
// Define ARB_LOCK_EN to build the lock path (LOCKED state and hold counter).
module reg_write_arbiter
  import reg_arb_pkg::*;
#(
  parameter int NUM_REQ = NUM_REQ_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int ADDR_W  = ADDR_W_DEF
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*DATA_W-1:0] wdata,
  input  logic [NUM_REQ*ADDR_W-1:0] waddr,
  input  logic [NUM_REQ-1:0]        lock,
  output logic [NUM_REQ-1:0]        gnt,
  output logic [2**ADDR_W-1:0]      reg_en,
  output logic [DATA_W-1:0]         reg_d,
  output logic [15:0]               wr_count
);
  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  arb_state_t           state;
  logic [PW-1:0]        last_winner, pick_idx;
  logic [NUM_REQ-1:0]   pick, sel;
  logic                 pick_vld, done, hold;
  logic [2**ADDR_W-1:0] en_nxt;
  logic [DATA_W-1:0]    d_nxt;

  assign done = (state != IDLE) && |(req & gnt);

  // The requester completing at this edge is masked out of the new pick.
  rr_pick #(.NUM_REQ(NUM_REQ), .PW(PW)) u_pick (
    .req   (req & ~gnt),
    .ptr   (last_winner),
    .win   (pick),
    .valid (pick_vld)
  );

`ifdef ARB_LOCK_EN
  localparam int HW = (LOCK_MAX > 1) ? $clog2(LOCK_MAX) : 1;
  logic [HW-1:0] hold_cnt;
  // hold_cnt = transfers already done in this hold run; the LOCK_MAX-th releases.
  assign hold = done && |(req & gnt & lock) && (hold_cnt != HW'(LOCK_MAX - 1));
`else
  logic unused_lock;
  assign unused_lock = ^lock;
  assign hold        = 1'b0;
`endif

  assign sel = hold ? gnt : pick;

  always_comb begin
    pick_idx = '0;
    en_nxt   = '0;
    d_nxt    = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pick[i]) pick_idx = PW'(i);
      if (sel[i]) begin
        en_nxt[waddr[i*ADDR_W +: ADDR_W]] = 1'b1;
        d_nxt = wdata[i*DATA_W +: DATA_W];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      gnt         <= '0;
      reg_en      <= '0;
      reg_d       <= '0;
      wr_count    <= '0;
      last_winner <= PW'(NUM_REQ - 1);
`ifdef ARB_LOCK_EN
      hold_cnt    <= '0;
`endif
    end else begin
      gnt    <= sel;
      reg_en <= en_nxt;
      reg_d  <= d_nxt;
      if (done) wr_count <= wr_count + 16'd1;
`ifdef ARB_LOCK_EN
      if (hold) begin
        state    <= LOCKED;
        hold_cnt <= hold_cnt + HW'(1);
      end else
`endif
      if (pick_vld) begin
        state       <= GRANT;
        last_winner <= pick_idx;
`ifdef ARB_LOCK_EN
        hold_cnt    <= '0;
`endif
      end else begin
        state <= IDLE;
      end
    end
  end
endmodule

// File: tb/tb_reg_write_arbiter.sv
// Bench for reg_write_arbiter: directed vector table, wrap/lock sequences, random vs model.
module tb_reg_write_arbiter;
  localparam int NR = 4;
  localparam int DW = 32;
  localparam int AW = 2;
  localparam int LMAX = 8;

  logic            clk = 1'b0;
  logic            rst;
  logic [NR-1:0]   req, lock, gnt;
  logic [NR*DW-1:0] wdata;
  logic [NR*AW-1:0] waddr;
  logic [3:0]      reg_en;
  logic [DW-1:0]   reg_d;
  logic [15:0]     wr_count;

  reg_write_arbiter #(.NUM_REQ(NR), .DATA_W(DW), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst), .req(req), .wdata(wdata), .waddr(waddr), .lock(lock),
    .gnt(gnt), .reg_en(reg_en), .reg_d(reg_d), .wr_count(wr_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s actual=%h expected=%h", name, act, exp);
  endtask

  // Reference model: owner index of the current grant, last winner, run length, count.
  int          m_g = -1;
  int          m_last = NR - 1;
  int          m_run = 0;
  logic [15:0] m_cnt = '0;
  logic [3:0]  e_gnt, e_en;
  logic [31:0] e_d;

  task automatic model_edge();
    bit done, hold;
    int prev;
    if (rst) begin
      m_g = -1; m_last = NR - 1; m_run = 0; m_cnt = '0;
    end else begin
      done = (m_g >= 0) && req[m_g];
      hold = 1'b0;
      if (done) m_cnt = m_cnt + 16'd1;
`ifdef ARB_LOCK_EN
      if (done) m_run++;
      hold = done && lock[m_g] && (m_run < LMAX);
`endif
      if (!hold) begin
        prev = m_g;
        m_g  = -1;
        for (int k = 1; k <= NR; k++) begin
          int i;
          i = (m_last + k) % NR;
          if (req[i] && i != prev) begin
            m_g = i; m_last = i; m_run = 0;
            break;
          end
        end
      end
    end
    e_gnt = '0; e_en = '0; e_d = '0;
    if (m_g >= 0) begin
      e_gnt[m_g] = 1'b1;
      e_en[waddr[m_g*AW +: AW]] = 1'b1;
      e_d = wdata[m_g*DW +: DW];
    end
  endtask

  task automatic step(input bit do_chk);
    @(posedge clk);
    model_edge();
    #1;
    if (do_chk) begin
      chk("mdl_gnt", 32'(gnt), 32'(e_gnt));
      chk("mdl_en", 32'(reg_en), 32'(e_en));
      chk("mdl_d", reg_d, e_d);
      chk("mdl_cnt", 32'(wr_count), 32'(m_cnt));
    end
  endtask

  typedef struct {
    logic        rst;
    logic [3:0]  req;
    logic [7:0]  waddr;
    logic [127:0] wdata;
    logic [3:0]  gnt;
    logic [3:0]  en;
    logic [31:0] d;
    logic [15:0] cnt;
  } vec_t;

  localparam int NV = 19;
  localparam logic [127:0] P1 = {96'h0, 32'hFFFF_FFFF};
  localparam logic [127:0] WA = {32'h4444_4444, 32'h3333_3333, 32'h2222_2222, 32'h1111_1111};
  localparam logic [127:0] WB = {64'h0, 32'hAAAA_AAAA, 32'h8000_0801};
  localparam logic [127:0] WC = {32'hD3D3_D3D3, 32'hCAFE_F00D, 64'h0};
  vec_t tbl [NV];

  initial begin
    rst = 1'b1; req = '0; lock = '0; waddr = '0; wdata = '0;
    tbl[0]  = '{1'b1, 4'h0, 8'h02, P1, 4'h0, 4'h0, 32'h0, 16'd0};
    tbl[1]  = '{1'b0, 4'h1, 8'h02, P1, 4'h1, 4'h4, 32'hFFFF_FFFF, 16'd0};
    tbl[2]  = '{1'b0, 4'h1, 8'h02, P1, 4'h0, 4'h0, 32'h0, 16'd1};
    tbl[3]  = '{1'b0, 4'h0, 8'h02, P1, 4'h0, 4'h0, 32'h0, 16'd1};
    tbl[4]  = '{1'b1, 4'hF, 8'hE4, WA, 4'h0, 4'h0, 32'h0, 16'd0};
    tbl[5]  = '{1'b0, 4'hF, 8'hE4, WA, 4'h1, 4'h1, 32'h1111_1111, 16'd0};
    tbl[6]  = '{1'b0, 4'hF, 8'hE4, WA, 4'h2, 4'h2, 32'h2222_2222, 16'd1};
    tbl[7]  = '{1'b0, 4'hF, 8'hE4, WA, 4'h4, 4'h4, 32'h3333_3333, 16'd2};
    tbl[8]  = '{1'b0, 4'hF, 8'hE4, WA, 4'h8, 4'h8, 32'h4444_4444, 16'd3};
    tbl[9]  = '{1'b0, 4'hF, 8'hE4, WA, 4'h1, 4'h1, 32'h1111_1111, 16'd4};
    tbl[10] = '{1'b1, 4'h3, 8'h05, WB, 4'h0, 4'h0, 32'h0, 16'd0};
    tbl[11] = '{1'b0, 4'h3, 8'h05, WB, 4'h1, 4'h2, 32'h8000_0801, 16'd0};
    tbl[12] = '{1'b0, 4'h3, 8'h05, WB, 4'h2, 4'h2, 32'hAAAA_AAAA, 16'd1};
    tbl[13] = '{1'b0, 4'h2, 8'h05, WB, 4'h0, 4'h0, 32'h0, 16'd2};
    tbl[14] = '{1'b0, 4'h4, 8'h30, WC, 4'h4, 4'h8, 32'hCAFE_F00D, 16'd2};
    tbl[15] = '{1'b1, 4'h4, 8'h30, WC, 4'h0, 4'h0, 32'h0, 16'd0};
    tbl[16] = '{1'b0, 4'h0, 8'h30, WC, 4'h0, 4'h0, 32'h0, 16'd0};
    tbl[17] = '{1'b0, 4'h8, 8'h30, WC, 4'h8, 4'h1, 32'hD3D3_D3D3, 16'd0};
    tbl[18] = '{1'b0, 4'h0, 8'h30, WC, 4'h0, 4'h0, 32'h0, 16'd0};

    for (int r = 0; r < NV; r++) begin
      rst = tbl[r].rst; req = tbl[r].req; waddr = tbl[r].waddr; wdata = tbl[r].wdata;
      step(1'b1);
      chk($sformatf("row%0d_gnt", r), 32'(gnt), 32'(tbl[r].gnt));
      chk($sformatf("row%0d_en", r), 32'(reg_en), 32'(tbl[r].en));
      chk($sformatf("row%0d_d", r), reg_d, tbl[r].d);
      chk($sformatf("row%0d_cnt", r), 32'(wr_count), 32'(tbl[r].cnt));
    end

`ifdef ARB_LOCK_EN
    rst = 1'b1; req = '0; lock = '0;
    step(1'b1);
    rst = 1'b0; req = 4'b0011; lock = 4'b0001; waddr = '0; wdata = WB;
    for (int k = 1; k <= LMAX + 1; k++) begin
      step(1'b1);
      chk($sformatf("lock_gnt%0d", k), 32'(gnt), (k <= LMAX) ? 32'h1 : 32'h2);
    end
    lock = '0;
`endif

    // Counter wrap: 65535 back-to-back transfers, then one more.
    rst = 1'b1; req = '0; waddr = 8'hE4; wdata = WA;
    step(1'b1);
    rst = 1'b0; req = 4'hF;
    repeat (65536) step(1'b0);
    chk("wrap_ffff", 32'(wr_count), 32'h0000_FFFF);
    step(1'b1);
    chk("wrap_zero", 32'(wr_count), 32'h0);

    for (int n = 0; n < 1500; n++) begin
      rst   = ($urandom_range(0, 63) == 0);
      req   = 4'($urandom);
      lock  = 4'($urandom);
      waddr = 8'($urandom);
      wdata = {$urandom, $urandom, $urandom, $urandom};
      step(1'b1);
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule

// File: doc/reg_write_arbiter.md
REG_WRITE_ARBITER -- requirements
Module: reg_write_arbiter

Interface
REQ-001 SHALL: parameters NUM_REQ, default 4, number of requesters; DATA_W, default 32, write data width; ADDR_W, default 2, register select width (4 x 32-bit registers).
REQ-002 SHALL: one clock; reset is synchronous and active-high; ports named clk and rst.
REQ-003 SHALL: clk  input  1  rising-edge clock.
REQ-004 SHALL: rst  input  1  synchronous active-high reset.
REQ-005 SHALL: req  input  NUM_REQ  per-requester write request; held until granted.
REQ-006 SHALL: wdata  input  NUM_REQ*DATA_W  per-requester write data; requester i uses slice [i*DATA_W +: DATA_W].
REQ-007 SHALL: waddr  input  NUM_REQ*ADDR_W  per-requester target register index.
REQ-008 SHALL: lock  input  NUM_REQ  per-requester hold-grant request; ignored unless ARB_LOCK_EN.
REQ-009 SHALL: gnt  output  NUM_REQ  one-hot grant, registered.
REQ-010 SHALL: reg_en  output  2**ADDR_W  one-hot register-bank enable, registered.
REQ-011 SHALL: reg_d  output  DATA_W  data driven to register-bank D inputs, registered.
REQ-012 SHALL: wr_count  output  16  count of completed transfers.

Function
REQ-013 SHALL: transfer for requester i completes at a rising edge where req[i]=1 and gnt[i]=1.
REQ-014 SHALL: arbitration at each edge over req & ~gnt (the just-completed requester is masked for that edge).
REQ-015 SHALL: round-robin order; search starts at last_winner+1 mod NUM_REQ; last_winner updates only when a new grant is issued.
REQ-016 SHALL: latency: req[i] sampled high at edge E and winning -> gnt[i], reg_en, reg_d valid throughout cycle after E; one cycle per transfer.
REQ-017 SHALL: back-to-back grants to different requesters in consecutive cycles; throughput one write per cycle.
REQ-018 SHALL: reg_en = one-hot decode of winner's waddr; reg_d = winner's wdata, both captured at the granting edge.
REQ-019 SHALL: no eligible request -> gnt=0, reg_en=0, reg_d=0 next cycle.
REQ-020 SHALL: FSM states IDLE (no grant), GRANT (single-cycle grant), LOCKED (ARB_LOCK_EN only); IDLE->GRANT on any eligible req; GRANT->GRANT on another eligible req; GRANT->IDLE otherwise.
REQ-021 SHALL: two requesters targeting the same register in the same cycle -> serialized by round-robin, never both enabled.
REQ-022 SHALL: wr_count increments by 1 per completed transfer; wraps 16'hFFFF -> 16'h0000.
REQ-023 SHALL: req dropped while gnt high -> no transfer counted; grant ends next edge.

Reset
REQ-024 SHALL: at rst edge: gnt=0, reg_en=0, reg_d=0, wr_count=0, state=IDLE, last_winner=NUM_REQ-1 (requester 0 first priority).
REQ-025 SHALL: rst asserted mid-grant aborts the grant; no transfer counted at that edge; rst dominates all inputs.

Configuration
REQ-026 SHALL: macro ARB_LOCK_EN defined: at a completing edge with lock[i]=1 and req[i]=1, state -> LOCKED, gnt[i] held, reg_en/reg_d re-captured, last_winner unchanged; forced release after LOCK_MAX=8 consecutive transfers, then normal round-robin from i+1.
REQ-027 SHALL: ARB_LOCK_EN undefined: lock port present but ignored, LOCKED state and hold counter not built.

Structure
REQ-028 SHALL: package reg_arb_pkg holds NUM_REQ, DATA_W, ADDR_W, LOCK_MAX defaults and the state enum type.
REQ-029 SHALL: combinational sub-module rr_pick (request vector + pointer -> one-hot winner, valid) instantiated once.

Verification
REQ-030 SHALL: rst=1 one edge, all req=0 -> gnt=0, reg_en=0, reg_d=0, wr_count=0.
REQ-031 SHALL: req=4'b0001, wdata0=32'hFFFFFFFF, waddr0=2 -> next cycle gnt=4'b0001, reg_en=4'b0100, reg_d=32'hFFFFFFFF; wr_count=1 after.
REQ-032 SHALL: req=4'b1111 held continuously -> gnt sequence 0001,0010,0100,1000,0001 on consecutive cycles; wr_count +1 each cycle.
REQ-033 SHALL: req=4'b0011 both waddr=1, wdata 32'h80000801 / 32'hAAAAAAAA -> two separate cycles, reg_en=4'b0010 each, data in grant order.
REQ-034 SHALL: rst asserted in a grant cycle of req=4'b0100 -> gnt=0 next cycle, wr_count unchanged; 16'hFFFF preloaded via 65535 transfers +1 -> wr_count=0.
REQ-035 SHALL: ARB_LOCK_EN, req=4'b0011, lock=4'b0001 -> gnt=0001 for 8 cycles then 0010.
